dmem_port_arbiter: RTL

Two-port arbiter that shares the single data-memory interface between two requesters: port 0 is the core memory stage, port 1 is a secondary master such as the debug or DMA path. It grants one request at a time with round-robin fairness. It tracks the single outstanding load until the memory returns data, then routes that data to the owning port. A watchdog recovers from a load that never completes.

---
 rtl/dmem_port_arbiter_if.sv | 66 ++++++
 rtl/dmem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Brief    : Bundles the two requester ports and the shared data-memory port
//             of the data-memory arbiter into a single interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);

  // Port 0: core memory stage
  logic                    req0_read;
  logic                    req0_write;
  logic [ADDRESS_BITS-1:0] req0_address;
  logic [DATA_WIDTH-1:0]   req0_data;
  logic                    req0_ready;
  logic                    req0_valid;
  logic [DATA_WIDTH-1:0]   req0_load_data;

  // Port 1: secondary master (debug / DMA)
  logic                    req1_read;
  logic                    req1_write;
  logic [ADDRESS_BITS-1:0] req1_address;
  logic [DATA_WIDTH-1:0]   req1_data;
  logic                    req1_ready;
  logic                    req1_valid;
  logic [DATA_WIDTH-1:0]   req1_load_data;

  // Shared memory side
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_in_data;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_out_data;

  // Status
  logic                    timeout_error;

  // Environment view: requesters and memory model drive the inputs
  modport master (
    output req0_read, req0_write, req0_address, req0_data,
    input  req0_ready, req0_valid, req0_load_data,
    output req1_read, req1_write, req1_address, req1_data,
    input  req1_ready, req1_valid, req1_load_data,
    input  mem_read, mem_write, mem_address, mem_in_data,
    output mem_ready, mem_valid, mem_out_data,
    input  timeout_error
  );

  // Arbiter view
  modport slave (
    input  req0_read, req0_write, req0_address, req0_data,
    output req0_ready, req0_valid, req0_load_data,
    input  req1_read, req1_write, req1_address, req1_data,
    output req1_ready, req1_valid, req1_load_data,
    output mem_read, mem_write, mem_address, mem_in_data,
    input  mem_ready, mem_valid, mem_out_data,
    output timeout_error
  );

endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Round-robin arbiter sharing one data-memory port between the
//             core memory stage (port 0) and a secondary master (port 1).
//             Tracks one outstanding load, routes its data back to the owning
//             port and recovers from a load that never returns via a watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
);

  // Watchdog fires when the counter reaches this value in WAIT_LOAD; the
  // counter reads 0 in the first wait cycle, so the fallback response lands
  // exactly TIMEOUT_CYCLES cycles after acceptance.
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_owner;
  logic                    r_last_grant;
  logic [15:0]             r_counter;
  logic                    r_timeout_error;

  logic                    w_req0;
  logic                    w_req1;
  logic                    w_grant_valid;
  logic                    w_grant_port;
  logic                    w_sel_read;
  logic                    w_sel_write;
  logic [ADDRESS_BITS-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  logic                    w_accept;
  logic                    w_accept_read;
  logic                    w_complete;
  logic                    w_timeout;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic                    w_mem_read;
  logic                    w_mem_write;
  logic [ADDRESS_BITS-1:0] w_mem_address;
  logic [DATA_WIDTH-1:0]   w_mem_in_data;

  // Round-robin grant: a lone requester wins; on a tie the port that was not
  // granted last wins. Re-evaluated every cycle until acceptance.
  always_comb begin
    w_req0        = bus.req0_read | bus.req0_write;
    w_req1        = bus.req1_read | bus.req1_write;
    w_grant_valid = w_req0 | w_req1;
    w_grant_port  = 1'b0;
    if (w_req0 && w_req1) begin
      w_grant_port = ~r_last_grant;
    end else if (w_req1) begin
      w_grant_port = 1'b1;
    end
  end

  // Select the granted port's request; a write strobe suppresses a
  // simultaneous read on the same port.
  always_comb begin
    w_sel_read    = 1'b0;
    w_sel_write   = 1'b0;
    w_sel_address = '0;
    w_sel_data    = '0;
    if (w_grant_valid) begin
      if (w_grant_port) begin
        w_sel_write   = bus.req1_write;
        w_sel_read    = bus.req1_read & ~bus.req1_write;
        w_sel_address = bus.req1_address;
        w_sel_data    = bus.req1_data;
      end else begin
        w_sel_write   = bus.req0_write;
        w_sel_read    = bus.req0_read & ~bus.req0_write;
        w_sel_address = bus.req0_address;
        w_sel_data    = bus.req0_data;
      end
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, memory request drive and load completion
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_accept_read = 1'b0;
    w_complete    = 1'b0;
    w_timeout     = 1'b0;
    w_load_data   = '0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_address = '0;
    w_mem_in_data = '0;
    case (r_state)
      ST_IDLE: begin
        // Stray mem_valid is ignored here: nothing is outstanding.
        if (w_grant_valid) begin
          w_mem_read    = w_sel_read;
          w_mem_write   = w_sel_write;
          w_mem_address = w_sel_address;
          w_mem_in_data = w_sel_data;
          if (bus.mem_ready) begin
            w_accept = 1'b1;
            if (w_sel_read) begin
              w_accept_read = 1'b1;
              w_state_next  = ST_WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT_LOAD: begin
        // Real data takes priority over the watchdog in the same cycle.
        if (bus.mem_valid) begin
          w_complete   = 1'b1;
          w_load_data  = bus.mem_out_data;
          w_state_next = ST_IDLE;
        end else if (r_counter == c_timeout_last) begin
          w_complete   = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Round-robin pointer and load owner update on acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_port;
      if (w_accept_read) begin
        r_owner <= w_grant_port;
      end
    end
  end

  // Watchdog counter: cleared when a load is accepted, counts while waiting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_counter <= '0;
    end else if (w_accept_read) begin
      r_counter <= '0;
    end else if (r_state == ST_WAIT_LOAD) begin
      r_counter <= r_counter + 16'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timeout_error <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_error <= 1'b1;
    end
  end

  // Output drive; everything is held at zero while reset is asserted
  always_comb begin
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b0;
    bus.req0_load_data = '0;
    bus.req1_load_data = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_in_data    = '0;
    bus.timeout_error  = 1'b0;
    if (!reset) begin
      bus.req0_ready    = w_accept & ~w_grant_port;
      bus.req1_ready    = w_accept &  w_grant_port;
      bus.mem_read      = w_mem_read;
      bus.mem_write     = w_mem_write;
      bus.mem_address   = w_mem_address;
      bus.mem_in_data   = w_mem_in_data;
      bus.timeout_error = r_timeout_error;
      if (w_complete) begin
        if (r_owner) begin
          bus.req1_valid     = 1'b1;
          bus.req1_load_data = w_load_data;
        end else begin
          bus.req0_valid     = 1'b1;
          bus.req0_load_data = w_load_data;
        end
      end
    end
  end

endmodule
`default_nettype wire
